// File: rtl/bridge_pkg.sv
// Shared encodings for the UART/RAM bridge: top-level states (doubling as LED status codes),
// byte-sender phases and the checksum seed.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_WAIT_END = 3'd1,
    ST_RD       = 3'd2,
    ST_CAP      = 3'd3,
    ST_SEND     = 3'd4,
    ST_TXWAIT   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_SEND,
    SND_WAIT1,
    SND_WAIT
  } snd_state_t;

  localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/tx_byte_sender.sv
// One-byte transmit handshake: latch byte on go, request when the transmitter is idle,
// then wait (skipping the first cycle after the request) for the transmitter to go idle.
module tx_byte_sender
  import bridge_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_launch,
  output logic       o_done
);

  snd_state_t r_ph;
  logic [7:0] r_tx_data;
  logic       r_tx_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph       <= SND_IDLE;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_ph)
        SND_IDLE: begin
          if (i_go) begin
            r_tx_data <= i_byte;
            r_ph      <= SND_SEND;
          end
        end
        SND_SEND: begin
          if (!i_tx_busy) begin
            r_tx_start <= 1'b1;
            r_ph       <= SND_WAIT1;
          end
        end
        // The transmitter may not have raised busy yet in the request cycle.
        SND_WAIT1: r_ph <= SND_WAIT;
        SND_WAIT: begin
          if (!i_tx_busy) r_ph <= SND_IDLE;
        end
        default: r_ph <= SND_IDLE;
      endcase
    end
  end

  // Combinational strobes let the parent state register track the handshake cycle-exactly.
  assign o_launch   = (r_ph == SND_SEND) && !i_tx_busy;
  assign o_done     = (r_ph == SND_WAIT) && !i_tx_busy;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule

// File: rtl/uart_ram_bridge.sv
// UART byte stream <-> RAM bridge: loads received bytes into RAM, then dumps a RAM window.
// Optional trailing XOR checksum byte when BRIDGE_CHECKSUM_EN is defined.
module uart_ram_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LOAD_WORDS = 256,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic              end_ops,
  output logic              load_done,
  output logic              dump_done,
  output logic              overrun,
  output logic [2:0]        status
);

  localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] DUMP_FIRST = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] DUMP_LAST  = ADDR_W'(DUMP_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_lptr, r_dptr, r_dcnt, r_ram_addr;
  logic [15:0]       r_ram_wdata;
  logic              r_ram_we, r_load_done, r_dump_done, r_overrun;
  logic [7:0]        w_byte;
  logic              w_go, w_launch, w_done, w_cks_pending, w_unused;

  assign w_go     = (r_state == ST_CAP);
  assign w_unused = ^ram_rdata[15:8];

`ifdef BRIDGE_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_cks;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= CSUM_SEED;
      r_cks  <= 1'b0;
    end else if (r_state == ST_CAP && !r_cks) begin
      r_csum <= r_csum ^ ram_rdata[7:0];
    end else if (r_state == ST_TXWAIT && w_done && r_dcnt == DUMP_LAST) begin
      r_cks <= 1'b1;
    end
  end

  assign w_byte        = r_cks ? r_csum : ram_rdata[7:0];
  assign w_cks_pending = !r_cks;
`else
  assign w_byte        = ram_rdata[7:0];
  assign w_cks_pending = 1'b0;
`endif

  tx_byte_sender u_sender (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_go       (w_go),
    .i_byte     (w_byte),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_launch   (w_launch),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_lptr      <= '0;
      r_dptr      <= '0;
      r_dcnt      <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_load_done <= 1'b0;
      r_dump_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      if (rx_valid && r_state != ST_LOAD) r_overrun <= 1'b1;
      case (r_state)
        ST_LOAD: begin
          if (rx_valid) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_lptr;
            r_ram_wdata <= {8'h00, rx_data};
            r_lptr      <= r_lptr + 1'b1;
            if (r_lptr == LOAD_LAST) begin
              r_load_done <= 1'b1;
              r_state     <= ST_WAIT_END;
            end
          end
        end
        // ram_addr is loaded on entry to RD so read data is valid during CAP.
        ST_WAIT_END: begin
          if (end_ops) begin
            r_dptr     <= DUMP_FIRST;
            r_dcnt     <= '0;
            r_ram_addr <= DUMP_FIRST;
            r_state    <= ST_RD;
          end
        end
        ST_RD:   r_state <= ST_CAP;
        ST_CAP:  r_state <= ST_SEND;
        ST_SEND: begin
          if (w_launch) r_state <= ST_TXWAIT;
        end
        ST_TXWAIT: begin
          if (w_done) begin
            if (r_dcnt != DUMP_LAST) begin
              r_dptr     <= r_dptr + 1'b1;
              r_dcnt     <= r_dcnt + 1'b1;
              r_ram_addr <= r_dptr + 1'b1;
              r_state    <= ST_RD;
            end else if (w_cks_pending) begin
              r_state <= ST_CAP;
            end else begin
              r_dump_done <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: r_dump_done <= 1'b1;
        default: r_state <= ST_DONE;
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign load_done = r_load_done;
  assign dump_done = r_dump_done;
  assign overrun   = r_overrun;
  assign status    = r_state;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed bench for uart_ram_bridge: RAM and UART transmitter models, load/dump/overrun/reset cases.
module tb_uart_ram_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic        end_ops;
  logic        load_done;
  logic        dump_done;
  logic        overrun;
  logic [2:0]  status;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_ram_bridge #(
    .ADDR_W     (16),
    .LOAD_WORDS (4),
    .DUMP_BASE  (0),
    .DUMP_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .end_ops   (end_ops),
    .load_done (load_done),
    .dump_done (dump_done),
    .overrun   (overrun),
    .status    (status)
  );

  // Synchronous RAM: read data valid one cycle after the address.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  // Transmitter: busy for 6 cycles starting the cycle after tx_start.
  int unsigned busy_cnt = 0;
  logic [7:0]  tx_log[$];
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (tx_start) begin
      busy_cnt <= 6;
      tx_log.push_back(tx_data);
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] we_addr[$];
  logic [15:0] we_data[$];
  logic        we_ld[$];
  int unsigned we_cyc[$];
  int unsigned n_txviol = 0;
  always @(negedge clk) begin
    if (ram_we) begin
      we_addr.push_back(ram_addr);
      we_data.push_back(ram_wdata);
      we_ld.push_back(load_done);
      we_cyc.push_back(cyc);
    end
    if (tx_start && tx_busy) n_txviol <= n_txviol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  logic [7:0] exp_b [4];
  logic [7:0] exp_tx [5];
`ifdef BRIDGE_CHECKSUM_EN
  localparam int N_TX = 5;
`else
  localparam int N_TX = 4;
`endif

  initial begin
    int n_we;
    exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    rx_valid = 1'b0;
    rx_data  = '0;
    end_ops  = 1'b0;

    #12;
    check("rst_ram_we", ram_we, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_load_done", load_done, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_status", status, 0);
    @(negedge clk);
    reset = 1'b0;

    end_ops = 1'b1;
    repeat (2) @(negedge clk);
    end_ops = 1'b0;
    @(negedge clk);
    check("end_ops_in_load_ignored", status, 0);

    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = exp_b[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = exp_b[3];
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);

    check("load_write_count", we_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("load_addr%0d", i), (i < we_addr.size()) ? we_addr[i] : 16'hDEAD, i);
      check($sformatf("load_data%0d", i), (i < we_data.size()) ? we_data[i] : 16'hDEAD,
            {8'h00, exp_b[i]});
      check($sformatf("load_done_at%0d", i), (i < we_ld.size()) ? we_ld[i] : 1'bx, (i == 3));
    end
    check("b2b_cyc1", (we_cyc.size() >= 2) ? we_cyc[1] - we_cyc[0] : 0, 1);
    check("b2b_cyc2", (we_cyc.size() >= 3) ? we_cyc[2] - we_cyc[0] : 0, 2);
    check("status_wait_end", status, 1);
    for (int i = 0; i < 4; i++)
      check($sformatf("ram%0d", i), mem[i], {8'h00, exp_b[i]});

    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("overrun_no_write", we_addr.size(), 4);
    check("overrun_stays_wait_end", status, 1);

    end_ops = 1'b1;
    @(negedge clk);
    end_ops = 1'b0;
    for (int i = 0; i < 3000 && !dump_done; i++) @(negedge clk);
    check("dump_done_timeout", dump_done, 1);
    repeat (20) @(negedge clk);
    check("tx_count", tx_log.size(), N_TX);
    for (int i = 0; i < N_TX; i++)
      check($sformatf("tx_byte%0d", i), (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_tx[i]);
    check("tx_start_while_busy", n_txviol, 0);
    check("status_done", status, 6);
    check("dump_done_sticky", dump_done, 1);
    check("no_write_in_dump", we_addr.size(), 4);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55 + 8'(i * 17);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    end_ops = 1'b1;
    @(negedge clk);
    end_ops = 1'b0;
    for (int i = 0; i < 500 && status != 3'd5; i++) @(negedge clk);
    check("reach_txwait", status, 5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ram_we", ram_we, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_load_done", load_done, 0);
    check("mid_rst_dump_done", dump_done, 0);
    check("mid_rst_ram_addr", ram_addr, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_status", status, 0);
    @(negedge clk);
    reset = 1'b0;

    n_we = we_addr.size();
    rx_valid = 1'b1;
    rx_data  = 8'hAB;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("restart_write_count", we_addr.size(), n_we + 1);
    check("restart_addr", (we_addr.size() > 0) ? we_addr[$] : 16'hDEAD, 0);
    check("restart_data", (we_data.size() > 0) ? we_data[$] : 16'hDEAD, 16'h00AB);
    check("restart_load_done", load_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
